keypad_scanner: RTL
===================

# keypad_scanner

Parametrised matrix-keypad scanner: drives one row low at a time, samples the active-low column inputs, debounces whole-frame results and delivers each key press as a single keycode event over a valid/ready handshake. It succeeds the fixed 4×3 scanner on the board and feeds the calculator entry logic.

## Interface
- ROWS, 4, number of row drive lines
- COLS, 3, number of column sense lines
- CLK_DIV, 2**20, CLOCK_50 cycles per scan step (one row)
- DEBOUNCE, 3, consecutive identical frames required before a result is accepted (≥1)
- REPEAT_FRAMES, 64, frames between auto-repeat events (used only with KEYPAD_REPEAT_EN)
- CODE_W, $clog2(ROWS*COLS+1), keycode width
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high
- cols  in  COLS  column sense, active-low, externally pulled up
- rows  out  ROWS  row drive, exactly one bit low
- keycode  out  CODE_W  code of reported key
- key_valid  out  1  event pending
- key_ready  in  1  consumer accepts event
- key_held  out  1  a debounced single key is currently down
- multi_key  out  1  debounced frame shows more than one key
- overrun  out  1  one-cycle pulse: event lost because key_valid was still high

## Operation
- cols pass through a 2-flop synchroniser before use.
- Step counter counts 0..CLK_DIV-1; tick on CLK_DIV-1. On tick: sample synchronised cols for the current row, then rotate the low bit of rows upward (bit ROWS-1 wraps to bit 0).
- Frame = ROWS ticks. At frame end, the frame result is NONE, SINGLE(index = row*COLS+col) or MULTI.
- Debounce: stable counter increments when the result equals the previous frame's result, resets to 1 otherwise; saturates at DEBOUNCE. Result becomes stable when the counter reaches DEBOUNCE.
- Stable SINGLE not yet reported: load keycode, assert key_valid, set key_held, mark reported.
- Stable NONE: clear key_held, multi_key and the reported mark (re-arm).
- Stable MULTI: multi_key=1, no event; key_held unchanged; a later stable SINGLE of a new key reports normally.
- Key change without intermediate release (stable SINGLE of a different index) is a new press and is reported.
- Keycode mapping: ROWS=4, COLS=3 uses the telephone map (1–9, *=10, 0, #=11); any other geometry uses the linear index.
- Handshake: event consumed when key_valid & key_ready; key_valid drops the next cycle unless a new event loads in the same cycle.
- New event while key_valid high and key_ready low: event discarded, keycode unchanged, overrun pulses.

## Timing
- Reset values: rows = all ones except bit 0 low; keycode=0, key_valid=0, key_held=0, multi_key=0, overrun=0; step counter, row index, debounce state cleared.
- Reset mid-frame or mid-handshake: pending event and partial frame discarded; scanning restarts at row 0.
- Press-to-event latency: key_valid rises the cycle after the frame-end tick of the DEBOUNCE-th identical frame; worst case (DEBOUNCE+1)·ROWS·CLK_DIV + 3 cycles.
- Simultaneous consume and load: valid stays 1, new keycode, no overrun.
- key_ready ignored while key_valid=0.

## Configuration
- KEYPAD_REPEAT_EN defined: while key_held and the same SINGLE stays stable, a further event with the same keycode is issued every REPEAT_FRAMES frames after the previous event; overrun rules apply.
- Undefined: exactly one event per press; REPEAT_FRAMES unused, no repeat counter synthesised.

## Structure
- Package keypad_pkg: frame-result enum (NONE, SINGLE, MULTI), telephone keycode map function, code constants STAR=10, HASH=11.
- Sub-module keypad_debounce: frame-result comparison, stable counter, reported mark, repeat counter; top holds divider, row rotation, synchroniser, event register.

## Test plan
- CLK_DIV=4, DEBOUNCE=2: hold row1/col1 low → single event keycode=5 after 2 stable frames, key_held=1; release → key_held=0 after 2 NONE frames.
- Bounce: toggle key every other frame for 6 frames → no event; then hold → exactly one event.
- key_ready low, press 5 then release then press 9 → first event held, overrun pulse on 9, keycode stays 5.
- Press row3/col0 and row3/col2 together → multi_key=1, no event; release one → event keycode=11.
- reset asserted one cycle before an event would load → no key_valid, rows=4'b1110 next cycle.
- KEYPAD_REPEAT_EN, REPEAT_FRAMES=3, key_ready=1, hold 0 for 10 frames after first event → 3 further events keycode=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and keycode mapping for the matrix keypad scanner.
package keypad_pkg;

  // Outcome of one complete scan frame
  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } frame_res_e;

  localparam int STAR = 10;
  localparam int HASH = 11;

  // Telephone layout: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  function automatic int tel_code(input int index);
    if (index < 9)        return index + 1;
    else if (index == 9)  return STAR;
    else if (index == 10) return 0;
    else                  return HASH;
  endfunction

  // Only the classic 4x3 pad gets the telephone map; other geometries report the linear index
  function automatic int key_code(input int index, input int n_rows, input int n_cols);
    if (n_rows == 4 && n_cols == 3) return tel_code(index);
    return index;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce, press detection and (optional) auto-repeat.
// Optional feature macro: KEYPAD_REPEAT_EN enables the auto-repeat counter.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int IDX_W         = 4,
  parameter int DEBOUNCE      = 3,
  parameter int REPEAT_FRAMES = 64
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             frame_end,
  input  frame_res_e       frame_res,
  input  logic [IDX_W-1:0] frame_idx,
  output logic             fire,
  output logic             key_held,
  output logic             multi_key
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  frame_res_e       prev_res;
  logic [IDX_W-1:0] prev_idx;
  logic [CNT_W-1:0] stable_cnt;
  logic             reported;
  logic [IDX_W-1:0] rep_idx;

  logic             same;
  logic [CNT_W-1:0] cnt_next;
  logic             stable;
  logic             new_press;
  logic             repeat_due;

  // Compare this frame with the previous one and decide whether it is a fresh stable press
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    same      = 1'b0;
    cnt_next  = CNT_W'(1);
    stable    = 1'b0;
    new_press = 1'b0;
    if (frame_res == prev_res)
      same = (frame_res != RES_SINGLE) || (frame_idx == prev_idx);
    if (same)
      cnt_next = (stable_cnt == CNT_W'(DEBOUNCE)) ? stable_cnt : stable_cnt + 1'b1;
    stable    = (cnt_next == CNT_W'(DEBOUNCE));
    new_press = stable && (frame_res == RES_SINGLE) && (!reported || frame_idx != rep_idx);
  end

  // Debounce history and the reported mark; the reported mark doubles as key_held
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (reset) begin
      prev_res   <= RES_NONE;
      prev_idx   <= '0;
      stable_cnt <= '0;
      reported   <= 1'b0;
      rep_idx    <= '0;
      multi_key  <= 1'b0;
    end else if (frame_end) begin
      prev_res   <= frame_res;
      prev_idx   <= frame_idx;
      stable_cnt <= cnt_next;
      if (stable) begin
        case (frame_res)
          RES_NONE: begin
            reported  <= 1'b0;
            multi_key <= 1'b0;
          end
          RES_SINGLE: begin
            if (new_press) begin
              reported <= 1'b1;
              rep_idx  <= frame_idx;
            end
          end
          RES_MULTI: multi_key <= 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

  logic [REP_W-1:0] rep_cnt;
  logic             same_hold;

  assign same_hold  = stable && (frame_res == RES_SINGLE) && reported && (frame_idx == rep_idx);
  assign repeat_due = same_hold && (rep_cnt == REP_W'(REPEAT_FRAMES - 1));

  // Frames held since the last event; any other frame restarts the interval
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if (frame_end) begin
      if (same_hold && !repeat_due) rep_cnt <= rep_cnt + 1'b1;
      else                          rep_cnt <= '0;
    end
  end
`else
  // Repeat disabled: folds to constant 0, REPEAT_FRAMES carries no meaning here
  assign repeat_due = (REPEAT_FRAMES < 0);
`endif

  assign fire     = frame_end && (new_press || repeat_due);
  assign key_held = reported;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning matrix keypad front end with valid/ready keycode events.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while a key stays held).
// The synchroniser adds two cycles of delay, so CLK_DIV must be at least 3.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 3,
  parameter int CLK_DIV       = 2**20,
  parameter int DEBOUNCE      = 3,
  parameter int REPEAT_FRAMES = 64,
  parameter int CODE_W        = $clog2(ROWS*COLS+1)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [COLS-1:0]   cols,
  output logic [ROWS-1:0]   rows,
  output logic [CODE_W-1:0] keycode,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              multi_key,
  output logic              overrun
);

  localparam int STEP_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [COLS-1:0]   cols_meta, cols_sync;
  logic [STEP_W-1:0] step_cnt;
  logic [ROW_W-1:0]  row_idx;
  logic [1:0]        acc_count;   // keys seen so far this frame, saturating at 2
  logic [CODE_W-1:0] acc_idx;

  logic              tick, last_row, frame_end;
  logic [1:0]        cnt_now;
  logic [CODE_W-1:0] idx_now;
  frame_res_e        frame_res;
  logic              fire;

  // Two-flop synchroniser on the asynchronous column lines (idle high)
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cols_meta <= '1;
      cols_sync <= '1;
    end else begin
      cols_meta <= cols;
      cols_sync <= cols_meta;
    end
  end

  assign tick      = (step_cnt == STEP_W'(CLK_DIV - 1));
  assign last_row  = (row_idx == ROW_W'(ROWS - 1));
  assign frame_end = tick && last_row;

  // Fold the current row's sample into the frame tally and classify the frame
  always_comb begin
    cnt_now   = acc_count;
    idx_now   = acc_idx;
    frame_res = RES_NONE;
    for (int c = 0; c < COLS; c++) begin
      if (!cols_sync[c]) begin
        if (cnt_now != 2'd2) cnt_now = cnt_now + 2'd1;
        idx_now = CODE_W'(row_idx * COLS) + CODE_W'(c);
      end
    end
    case (cnt_now)
      2'd0:    frame_res = RES_NONE;
      2'd1:    frame_res = RES_SINGLE;
      default: frame_res = RES_MULTI;
    endcase
  end

  // Step divider, row rotation and per-frame accumulation
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      step_cnt  <= '0;
      row_idx   <= '0;
      rows      <= ~ROWS'(1);
      acc_count <= '0;
      acc_idx   <= '0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      if (tick) begin
        rows    <= (rows << 1) | (rows >> (ROWS - 1));
        row_idx <= last_row ? '0 : row_idx + 1'b1;
        if (last_row) begin
          acc_count <= '0;
          acc_idx   <= '0;
        end else begin
          acc_count <= cnt_now;
          acc_idx   <= idx_now;
        end
      end
    end
  end

  keypad_debounce #(
    .IDX_W        (CODE_W),
    .DEBOUNCE     (DEBOUNCE),
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) u_debounce (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .frame_end(frame_end),
    .frame_res(frame_res),
    .frame_idx(idx_now),
    .fire     (fire),
    .key_held (key_held),
    .multi_key(multi_key)
  );

  // Event register: load on fire unless an unconsumed event blocks it, then flag overrun
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      keycode   <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (fire) begin
        if (!key_valid || key_ready) begin
          keycode   <= CODE_W'(key_code(int'(idx_now), ROWS, COLS));
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule
